// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: round-robin whole-packet arbiter sharing one uart_tx among NUM_REQ byte streams.
// Optional feature macro: UART_ARB_TAG_EN (prefix each grant with tag byte {4'hA, owner index}).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [8*NUM_REQ-1:0] req_byte_in,
  input  logic [NUM_REQ-1:0]   req_last_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic                 tx_valid_out,
  output logic [7:0]           tx_byte_out,
  input  logic                 tx_ready_in,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 busy_out
);

  // state | meaning
  // IDLE  | no owner; pick first valid requester at/after rr_ptr
  // TAG   | offer tag byte for the new owner (UART_ARB_TAG_EN only)
  // PASS  | owner's stream passed combinationally to uart_tx

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_PASS = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [7:0]         r_byte_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;

  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_sel_valid;
  logic [7:0]         w_sel_byte;
  logic               w_sel_last;
  logic               w_xfer;
  logic               w_at_limit;
  logic               w_release;
  logic [IDX_W-1:0]   w_ptr_next;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int w_scan;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_scan     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid_in[IDX_W'(w_scan)]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = IDX_W'(w_scan);
      end
    end
  end

  assign w_sel_valid = req_valid_in[r_gidx];
  assign w_sel_byte  = req_byte_in[{r_gidx, 3'b000} +: 8];
  assign w_sel_last  = req_last_in[r_gidx];

`ifdef UART_ARB_TAG_EN
  logic [3:0] w_tag_idx;
  assign w_tag_idx = 4'(r_gidx);
`endif

  always_comb begin
    tx_valid_out  = 1'b0;
    tx_byte_out   = 8'h00;
    req_ready_out = '0;
    case (r_state)
      S_PASS: begin
        tx_valid_out          = w_sel_valid;
        tx_byte_out           = w_sel_byte;
        req_ready_out[r_gidx] = tx_ready_in;
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        tx_valid_out = 1'b1;
        tx_byte_out  = {4'hA, w_tag_idx};
      end
`endif
      default: ;
    endcase
  end

  assign w_xfer     = tx_valid_out && tx_ready_in;
  assign w_at_limit = ({1'b0, r_byte_cnt} + 9'd1) == 9'(MAX_PKT_LEN);
  assign w_release  = (r_state == S_PASS) && w_xfer && (w_sel_last || w_at_limit);
  assign w_ptr_next = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= 8'd0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_gidx     <= w_pick_idx;
            r_grant    <= NUM_REQ'(1) << w_pick_idx;
            r_busy     <= 1'b1;
            r_byte_cnt <= 8'd0;
`ifdef UART_ARB_TAG_EN
            r_state    <= S_TAG;
`else
            r_state    <= S_PASS;
`endif
          end
        end
        S_TAG: begin
          if (w_xfer) r_state <= S_PASS;
        end
        S_PASS: begin
          if (w_release) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_byte_cnt <= 8'd0;
            r_rr_ptr   <= w_ptr_next;
          end else if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_out = r_grant;
  assign busy_out  = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_arbiter: packet-level round-robin scheduler as reference,
// cycle-level scoreboard on the tx side, randomized ready/stall/traffic.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXL = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_byte;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_byte_in(req_byte), .req_last_in(req_last),
    .req_ready_out(req_ready),
    .tx_valid_out(tx_valid), .tx_byte_out(tx_byte), .tx_ready_in(tx_ready),
    .grant_out(grant), .busy_out(busy)
  );

  typedef struct {
    int         req;
    logic [7:0] b;
    bit         tag;
    bit         first;
    bit         fin;
  } exp_t;

  logic [8:0] rq[N][$];   // {last, byte} per requester
  exp_t       exp_q[$];
  int         grant_order[$];
  logic [7:0] obs[$];
  int         stall_cnt[N];
  int         checks = 0, errors = 0;
  int         m_ptr = 0;
  int         ready_pct = 100;
  bit         rand_stall = 0;
  int         force_req = -1, force_len = 0;
  bit         chk_idle = 0, chk_grant = 0;
  int         data_cnt = 0;

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  // Packet-level round-robin: whole packets, split every MAXL bytes, pointer to owner+1.
  task automatic schedule();
    logic [8:0] cq[N][$];
    int p, g, n;
    bit done;
    logic [8:0] v;
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    p = m_ptr;
    forever begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && cq[(p + k) % N].size() > 0) g = (p + k) % N;
      if (g < 0) break;
`ifdef UART_ARB_TAG_EN
      exp_q.push_back('{g, {4'hA, 4'(g)}, 1'b1, 1'b1, 1'b0});
`endif
      n = 0;
      done = 0;
      while (!done) begin
        v = cq[g].pop_front();
        n++;
        done = v[8] || (n == MAXL);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back('{g, v[7:0], 1'b0, 1'b0, done});
`else
        exp_q.push_back('{g, v[7:0], 1'b0, (n == 1), done});
`endif
      end
      p = (g + 1) % N;
    end
    m_ptr = p;
  endtask

  task automatic add_rand_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) rq[r].push_back({(j == len - 1), 8'($urandom)});
  endtask

  task automatic cycle();
    exp_t e;
    bit   tx_xfer;
    int   nreq, rq_i;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && stall_cnt[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_byte[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_byte[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    tx_ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    checks++;
    if ($countones(req_ready) > 1 || (req_ready & ~grant) != 0) begin
      errors++;
      $display("FAIL ready_onehot ready=%b grant=%b required at most one ready bit, within grant", req_ready, grant);
    end
    if (chk_idle) begin
      checks++;
      if (busy !== 1'b0 || grant !== '0 || tx_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL idle_cycle busy=%b grant=%b tx_valid=%b ready=%b required all 0", busy, grant, tx_valid, req_ready);
      end
      chk_idle  = 0;
      chk_grant = 1;
    end else if (chk_grant) begin
      chk_grant = 0;
      if (exp_q.size() > 0) begin
        checks++;
        if (grant !== onehot(exp_q[0].req) || busy !== 1'b1) begin
          errors++;
          $display("FAIL arb_latency grant=%b busy=%b required grant=%b busy=1", grant, busy, onehot(exp_q[0].req));
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (stall_cnt[k] > 0) begin
        checks++;
        if (tx_valid !== 1'b0 || grant !== onehot(k)) begin
          errors++;
          $display("FAIL stall_hold tx_valid=%b grant=%b required tx_valid=0 grant=%b", tx_valid, grant, onehot(k));
        end
      end
    end
    tx_xfer = (tx_valid === 1'b1) && tx_ready;
    nreq = 0;
    rq_i = -1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i] === 1'b1) begin nreq++; rq_i = i; end
    for (int k = 0; k < N; k++) if (stall_cnt[k] > 0) stall_cnt[k]--;
    if (tx_xfer) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte byte=%02h grant=%b required no transfer", tx_byte, grant);
      end else begin
        e = exp_q.pop_front();
        if (tx_byte !== e.b || grant !== onehot(e.req) || busy !== 1'b1) begin
          errors++;
          $display("FAIL xfer byte=%02h grant=%b busy=%b required byte=%02h grant=%b busy=1",
                   tx_byte, grant, busy, e.b, onehot(e.req));
        end
        checks++;
        if (nreq != (e.tag ? 0 : 1) || (!e.tag && rq_i != e.req)) begin
          errors++;
          $display("FAIL req_handshake ready=%b count=%0d required ready only on requester %0d (tag=%0d)",
                   req_ready, nreq, e.req, e.tag);
        end
        if (e.first) grant_order.push_back(e.req);
        if (e.fin) chk_idle = 1;
        if (!e.tag) begin
          obs.push_back(tx_byte);
          data_cnt++;
          if (rq_i >= 0 && rq[rq_i].size() > 0) begin
            void'(rq[rq_i].pop_front());
            if (!e.fin) begin
              if (force_req == rq_i) begin
                stall_cnt[rq_i] = force_len;
                force_req = -1;
              end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                stall_cnt[rq_i] = $urandom_range(1, 6);
              end
            end
          end
        end
      end
    end else begin
      checks++;
      if (nreq != 0) begin
        errors++;
        $display("FAIL req_without_tx ready=%b tx_valid=%b required no requester transfer", req_ready, tx_valid);
      end
    end
  endtask

  task automatic start_test();
    grant_order.delete();
    obs.delete();
    schedule();
    chk_idle  = 1;
    chk_grant = 0;
  endtask

  task automatic run_until_done(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin cycle(); c++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout remaining=%0d required 0 after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin rq[i].delete(); stall_cnt[i] = 0; end
    end
    cycle();
    cycle();
    chk_grant = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_byte = 32'($urandom);
    req_last = '1;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid got=%b required 0", tx_valid); end
    checks++; if (tx_byte !== 8'h00)  begin errors++; $display("FAIL reset_tx_byte got=%02h required 00", tx_byte); end
    checks++; if (req_ready !== '0)   begin errors++; $display("FAIL reset_ready got=%b required 0", req_ready); end
    checks++; if (grant !== '0)       begin errors++; $display("FAIL reset_grant got=%b required 0", grant); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b required 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    cycle();
    cycle();
  endtask

  task automatic test_single_packet();
    rq[2].push_back(9'h011); rq[2].push_back(9'h022); rq[2].push_back(9'h133);
    start_test();
    run_until_done(300);
    checks++;
    if (obs.size() != 3 || obs[0] !== 8'h11 || obs[1] !== 8'h22 || obs[2] !== 8'h33) begin
      errors++; $display("FAIL single_bytes got %0d bytes required 11 22 33", obs.size());
    end
    checks++;
    if (grant_order.size() != 1 || grant_order[0] != 2) begin
      errors++; $display("FAIL single_grant grants=%0d required one grant to requester 2", grant_order.size());
    end
  endtask

  task automatic test_round_robin();
    int want[5] = '{0, 1, 2, 3, 0};
    bit ok;
    add_rand_pkt(3, 2);   // owner 3 wraps the pointer back to 0
    start_test();
    run_until_done(300);
    for (int i = 0; i < N; i++) add_rand_pkt(i, 2);
    add_rand_pkt(0, 2);
    start_test();
    run_until_done(600);
    ok = (grant_order.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (grant_order[i] != want[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_order grants=%0d required order 0 1 2 3 0", grant_order.size()); end
  endtask

  task automatic test_force_release();
    logic [7:0] want[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h31, 8'h32, 8'h05, 8'h06};
    bit ok;
    for (int j = 1; j <= 6; j++) rq[1].push_back({(j == 6), 8'(j)});
    rq[3].push_back(9'h031); rq[3].push_back(9'h132);
    start_test();
    run_until_done(600);
    ok = (obs.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (obs[i] !== want[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL force_release_bytes got %0d bytes required 01 02 03 04 31 32 05 06", obs.size()); end
  endtask

  task automatic test_coincident();
    int want[3] = '{2, 3, 0};
    bit ok;
    add_rand_pkt(2, MAXL);
    add_rand_pkt(3, 1);
    add_rand_pkt(0, 1);
    start_test();
    run_until_done(400);
    ok = (grant_order.size() == 3);
    for (int i = 0; i < 3 && ok; i++) if (grant_order[i] != want[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL coincident_order grants=%0d required order 2 3 0", grant_order.size()); end
  endtask

  task automatic test_stall();
    add_rand_pkt(0, 3);
    add_rand_pkt(1, 2);
    add_rand_pkt(3, 2);
    force_req = 0;
    force_len = 100;
    start_test();
    run_until_done(1000);
    checks++;
    if (force_req != -1) begin errors++; $display("FAIL stall_applied pending=%0d required stall consumed", force_req); end
    force_req = -1;
  endtask

  task automatic test_random();
    rand_stall = 1;
    ready_pct = 60;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++)
        repeat ($urandom_range(0, 2)) add_rand_pkt(i, $urandom_range(1, 7));
      start_test();
      run_until_done(3000);
    end
    rand_stall = 0;
    ready_pct = 100;
  endtask

  task automatic test_reset_mid();
    int c = 0;
    int want[2] = '{1, 3};
    add_rand_pkt(2, 5);
    start_test();
    data_cnt = 0;
    while (data_cnt < 1 && c < 200) begin cycle(); c++; end
    checks++;
    if (data_cnt < 1) begin errors++; $display("FAIL reset_mid_start bytes=%0d required 1", data_cnt); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin rq[i].delete(); stall_cnt[i] = 0; end
    chk_idle = 0;
    chk_grant = 0;
    @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || req_ready !== '0 || grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs tx_valid=%b byte=%02h ready=%b grant=%b busy=%b required all 0",
               tx_valid, tx_byte, req_ready, grant, busy);
    end
    rst = 1'b0;
    add_rand_pkt(1, 1);
    add_rand_pkt(3, 1);
    m_ptr = 0;
    start_test();
    run_until_done(300);
    checks++;
    if (grant_order.size() != 2 || grant_order[0] != want[0] || grant_order[1] != want[1]) begin
      errors++; $display("FAIL reset_mid_ptr grants=%0d required order 1 3", grant_order.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_byte = '0;
    req_last = '0;
    tx_ready = 1'b0;
    for (int i = 0; i < N; i++) stall_cnt[i] = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_force_release();
    test_coincident();
    test_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter sharing the single `uart_tx` serializer among `NUM_REQ` byte-stream requesters. Grants whole packets (delimited by `last`), presents the granted stream to `uart_tx` using its valid/ready handshake, and forces release after `MAX_PKT_LEN` bytes so no requester can hold the line indefinitely. Sits directly in front of `uart_tx`; its `tx_*` ports connect to that block's `valid_in`, `byte_in` and `ready_out`.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–16.
- `MAX_PKT_LEN`, default 64: maximum bytes per grant; legal range 1–255.
- `clk_in`  in  1  system clock, 100 MHz.
- `rst_in`  in  1  synchronous, active-high reset.
- `req_valid_in`  in  NUM_REQ  per-requester byte valid.
- `req_byte_in`  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- `req_last_in`  in  NUM_REQ  marks the final byte of the packet; qualified by valid.
- `req_ready_out`  out  NUM_REQ  per-requester ready; at most one bit high.
- `tx_valid_out`  out  1  to `uart_tx` `valid_in`.
- `tx_byte_out`  out  8  to `uart_tx` `byte_in`.
- `tx_ready_in`  in  1  from `uart_tx` `ready_out`.
- `grant_out`  out  NUM_REQ  one-hot current owner; all zero in IDLE.
- `busy_out`  out  1  high in any state other than IDLE.

## Operation
- A transfer occurs on a cycle with `tx_valid_out && tx_ready_in`. A requester transfer occurs when `req_valid_in[i] && req_ready_out[i]`.
- State machine:
  - IDLE: no grant. If any `req_valid_in` is high, select the first valid index at or after `rr_ptr` (wrapping modulo NUM_REQ). Register the grant, clear `byte_cnt`, and move to TAG (with the macro) or PASS (without it).
  - TAG: described under Configuration.
  - PASS: combinational pass-through from the granted requester g.
    - `tx_valid_out = req_valid_in[g]`
    - `tx_byte_out = req_byte_in[g]`
    - `req_ready_out[g] = tx_ready_in`; all other ready bits are 0.
    - On each transfer, `byte_cnt` increments.
    - Release occurs on a transfer with `req_last_in[g]` high, or on the transfer that makes `byte_cnt == MAX_PKT_LEN`. On release: go to IDLE and set `rr_ptr = (g+1) mod NUM_REQ`.
- A force-released requester whose packet is not complete re-arbitrates as a new packet; remaining bytes are not merged into the earlier grant.
- A requester dropping valid mid-packet keeps the grant, and `tx_valid_out` stays low. Requesters must not abandon packets.
- Ungranted requesters see ready = 0. Their valid and data are ignored and must be held by the requester.
- `byte_cnt` is 8 bits and saturates logically at MAX_PKT_LEN. It never wraps.
- Reset values: state IDLE, `rr_ptr` 0, `byte_cnt` 0, grant 0. All outputs are 0, including `tx_byte_out = 8'h00` and `req_ready_out = 0`.
- Reset mid-packet aborts immediately. A byte already accepted by `uart_tx` completes at that block's discretion; the arbiter offers nothing until re-arbitration.

## Timing
- Arbitration latency: a request seen in IDLE in cycle N produces a grant and `busy_out` in cycle N+1, with the first byte (or tag) offered in N+1.
- After release, IDLE lasts exactly one cycle. Back-to-back packets therefore have a 1-cycle bubble in addition to `uart_tx` busy time.
- No pipeline registers sit on the data path in PASS; ready/valid are combinational through the block.
- If `last` and the MAX_PKT_LEN limit coincide on the same transfer, there is a single release and the pointer advances once.

## Configuration
- `UART_ARB_TAG_EN`, when defined: each grant enters TAG before PASS.
  - TAG drives `tx_valid_out = 1` and `tx_byte_out = {4'hA, g[3:0]}`, with all `req_ready_out` at 0.
  - TAG moves to PASS on transfer.
  - The tag byte does not count toward `byte_cnt`.
- Undefined: IDLE goes directly to PASS and no header bytes are emitted.

## Test plan
- Single packet: requester 2 sends 0x11, 0x22, 0x33 (last on 0x33) through real `uart_tx`, sampling the line every 33 cycles.
  - Required: serial bytes 0x11, 0x22, 0x33 (with tag: 0xA2 first).
  - Required: `grant_out = 4'b0100` throughout, then 0.
- Round-robin fairness: all 4 requesters hold 2-byte packets.
  - Required: grant order 0, 1, 2, 3, 0.
  - Required: `rr_ptr` wraps, and every packet completes contiguously with no interleaving.
- Force release: `MAX_PKT_LEN = 4`, requester 1 streams 6 bytes 0x01..0x06 with last on 0x06, and requester 3 is also requesting.
  - Required output: 0x01..0x04, then requester 3's packet, then 0x05, 0x06.
- Coincident last and limit: `MAX_PKT_LEN = 3`, 3-byte packet.
  - Required: exactly one release and one pointer increment.
- Mid-packet stall: requester 0 drops valid for 100 cycles after byte 1.
  - Required: grant held, `tx_valid_out` = 0 during the gap, no bytes from other requesters.
- Reset mid-packet: assert `rst_in` for 1 cycle during byte 2 of a 5-byte packet.
  - Required next cycle: all outputs 0 and `busy_out` = 0.
  - Required: the next arbitration starts from requester 0.
